// File: rtl/store_buffer.sv
// Store buffer: in-order FIFO of pending stores that shares the data-memory port
// with loads, draining when the port is idle or the buffer is full.
module store_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     st_valid,
  input  logic [31:0]              st_addr,
  input  logic [31:0]              st_data,
  input  logic [1:0]               st_op,
  input  logic [31:0]              st_pc,
  output logic                     st_ready,
  input  logic                     ld_valid,
  input  logic [31:0]              ld_addr,
  input  logic [1:0]               ld_op,
  output logic                     ld_stall,
  output logic                     dm_we,
  output logic [31:0]              dm_addr,
  output logic [31:0]              dm_wd,
  output logic [1:0]               dm_op,
  output logic [31:0]              dm_pc,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  op;
    logic [31:0] pc;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic          full;
  logic          enq;
  logic          drain;
  logic          buf_hit;
  logic          st_hit;
  logic [PW-1:0] offs;

  assign full     = (count == CW'(DEPTH));
  assign st_ready = reset && !full;
  assign enq      = st_valid && st_ready;
  // Loads own the port unless the buffer is full and must make room.
  assign drain    = reset && (count != '0) && (!ld_valid || full);
  assign st_hit   = enq && (st_addr[31:2] == ld_addr[31:2]);
  assign ld_stall = reset && ld_valid && (full || buf_hit || st_hit);

  // Word-granular address match against every live entry, including the head.
  always_comb begin
    buf_hit = 1'b0;
    offs    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offs = PW'(i) - head;
      if ((CW'(offs) < count) && (mem[i].addr[31:2] == ld_addr[31:2])) begin
        buf_hit = 1'b1;
      end
    end
  end

  always_comb begin
    dm_we   = 1'b0;
    dm_addr = ld_addr;
    dm_wd   = '0;
    dm_op   = ld_op;
    dm_pc   = '0;
    if (drain) begin
      dm_we   = 1'b1;
      dm_addr = mem[head].addr;
      dm_wd   = mem[head].data;
      dm_op   = mem[head].op;
      dm_pc   = mem[head].pc;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) begin
        tail <= tail + PW'(1);
      end
      if (drain) begin
        head <= head + PW'(1);
      end
      count <= count + CW'(enq) - CW'(drain);
    end
  end

  // Entry payload needs no reset; liveness comes from head/count.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem[tail] <= '{addr: st_addr, data: st_data, op: st_op, pc: st_pc};
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer (DEPTH = 4).
module tb_store_buffer;

  logic        clk;
  logic        reset;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [1:0]  st_op;
  logic [31:0] st_pc;
  logic        st_ready;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic [1:0]  ld_op;
  logic        ld_stall;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wd;
  logic [1:0]  dm_op;
  logic [31:0] dm_pc;
  logic [2:0]  count;

  int n_cmp = 0;
  int n_err = 0;

  store_buffer #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_op(st_op),
    .st_pc(st_pc), .st_ready(st_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_op(ld_op), .ld_stall(ld_stall),
    .dm_we(dm_we), .dm_addr(dm_addr), .dm_wd(dm_wd), .dm_op(dm_op), .dm_pc(dm_pc),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle();
    st_valid = 1'b0; st_addr = '0; st_data = '0; st_op = '0; st_pc = '0;
    ld_valid = 1'b0; ld_addr = '0; ld_op = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] op);
    st_valid = 1'b1; st_addr = a; st_data = d; st_op = op; st_pc = a + 32'h8000_0000;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    store(32'h40, 32'h1, 2'b00);
    ld_valid = 1'b1; ld_addr = 32'h40;
    tick();
    #1;
    n_cmp++; if (st_ready !== 1'b0) begin n_err++; $display("FAIL rst_st_ready got %b want 0", st_ready); end
    n_cmp++; if (ld_stall !== 1'b0) begin n_err++; $display("FAIL rst_ld_stall got %b want 0", ld_stall); end
    n_cmp++; if (dm_we !== 1'b0) begin n_err++; $display("FAIL rst_dm_we got %b want 0", dm_we); end
    tick();
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL rst_count got %0d want 0", count); end
    idle();
    reset = 1'b1;
    #1;
    n_cmp++; if (st_ready !== 1'b1) begin n_err++; $display("FAIL rel_st_ready got %b want 1", st_ready); end
    n_cmp++; if (dm_we !== 1'b0) begin n_err++; $display("FAIL rel_dm_we got %b want 0", dm_we); end
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL rel_count got %0d want 0", count); end
    tick();
  endtask

  task automatic test_single_store();
    store(32'h10, 32'h1234_5678, 2'b00);
    #1;
    n_cmp++; if (dm_we !== 1'b0) begin n_err++; $display("FAIL single_nobypass got %b want 0", dm_we); end
    tick();
    idle();
    #1;
    n_cmp++; if (count !== 3'd1) begin n_err++; $display("FAIL single_count1 got %0d want 1", count); end
    n_cmp++; if (dm_we !== 1'b1) begin n_err++; $display("FAIL single_we got %b want 1", dm_we); end
    n_cmp++; if (dm_addr !== 32'h10) begin n_err++; $display("FAIL single_addr got %h want 00000010", dm_addr); end
    n_cmp++; if (dm_wd !== 32'h1234_5678) begin n_err++; $display("FAIL single_wd got %h want 12345678", dm_wd); end
    n_cmp++; if (dm_pc !== 32'h8000_0010) begin n_err++; $display("FAIL single_pc got %h want 80000010", dm_pc); end
    tick();
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL single_count0 got %0d want 0", count); end
    n_cmp++; if (dm_we !== 1'b0) begin n_err++; $display("FAIL single_we_after got %b want 0", dm_we); end
  endtask

  task automatic test_fill();
    logic [31:0] a;
    ld_valid = 1'b1; ld_addr = 32'h100; ld_op = 2'b00;
    for (int i = 0; i < 4; i++) begin
      a = 32'h200 + 32'(4 * i);
      store(a, 32'hF0 + 32'(i), 2'b00);
      #1;
      n_cmp++; if (dm_we !== 1'b0) begin n_err++; $display("FAIL fill_we_%0d got %b want 0", i, dm_we); end
      tick();
    end
    store(32'h300, 32'hDEAD, 2'b00);
    #1;
    n_cmp++; if (count !== 3'd4) begin n_err++; $display("FAIL fill_count got %0d want 4", count); end
    n_cmp++; if (st_ready !== 1'b0) begin n_err++; $display("FAIL fill_st_ready got %b want 0", st_ready); end
    n_cmp++; if (ld_stall !== 1'b1) begin n_err++; $display("FAIL fill_ld_stall got %b want 1", ld_stall); end
    n_cmp++; if (dm_we !== 1'b1) begin n_err++; $display("FAIL fill_drain_we got %b want 1", dm_we); end
    n_cmp++; if (dm_addr !== 32'h200) begin n_err++; $display("FAIL fill_drain_addr got %h want 00000200", dm_addr); end
    tick();
    st_valid = 1'b0;
    #1;
    n_cmp++; if (count !== 3'd3) begin n_err++; $display("FAIL fill_count3 got %0d want 3", count); end
    n_cmp++; if (st_ready !== 1'b1) begin n_err++; $display("FAIL fill_ready_again got %b want 1", st_ready); end
    n_cmp++; if (ld_stall !== 1'b0) begin n_err++; $display("FAIL fill_stall_clear got %b want 0", ld_stall); end
    n_cmp++; if (dm_we !== 1'b0 || dm_addr !== 32'h100) begin
      n_err++; $display("FAIL fill_load_port got we=%b addr=%h want we=0 addr=00000100", dm_we, dm_addr);
    end
    ld_valid = 1'b0;
    for (int i = 1; i < 4; i++) begin
      #1;
      a = 32'h200 + 32'(4 * i);
      n_cmp++; if (dm_we !== 1'b1 || dm_addr !== a || dm_wd !== 32'hF0 + 32'(i)) begin
        n_err++; $display("FAIL fill_order_%0d got we=%b addr=%h wd=%h want we=1 addr=%h wd=%h",
                          i, dm_we, dm_addr, dm_wd, a, 32'hF0 + 32'(i));
      end
      tick();
    end
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL fill_empty got %0d want 0", count); end
    idle();
  endtask

  task automatic test_conflict();
    store(32'h20, 32'hAA, 2'b00);
    tick();
    idle();
    ld_valid = 1'b1; ld_addr = 32'h22; ld_op = 2'b01;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_cmp++; if (ld_stall !== 1'b1 || dm_we !== 1'b0) begin
        n_err++; $display("FAIL conflict_stall_%0d got stall=%b we=%b want stall=1 we=0", i, ld_stall, dm_we);
      end
      tick();
    end
    ld_valid = 1'b0;
    #1;
    n_cmp++; if (dm_we !== 1'b1 || dm_addr !== 32'h20) begin
      n_err++; $display("FAIL conflict_drain got we=%b addr=%h want we=1 addr=00000020", dm_we, dm_addr);
    end
    tick();
    ld_valid = 1'b1;
    #1;
    n_cmp++; if (ld_stall !== 1'b0) begin n_err++; $display("FAIL conflict_released got %b want 0", ld_stall); end
    n_cmp++; if (dm_we !== 1'b0 || dm_addr !== 32'h22 || dm_op !== 2'b01 || dm_wd !== 32'h0 || dm_pc !== 32'h0) begin
      n_err++; $display("FAIL conflict_load_port got we=%b addr=%h op=%b wd=%h pc=%h want 0/00000022/01/0/0",
                        dm_we, dm_addr, dm_op, dm_wd, dm_pc);
    end
    tick();
    idle();
  endtask

  task automatic test_same_cycle();
    store(32'h30, 32'h55, 2'b10);
    ld_valid = 1'b1; ld_addr = 32'h33; ld_op = 2'b10;
    #1;
    n_cmp++; if (ld_stall !== 1'b1 || dm_we !== 1'b0) begin
      n_err++; $display("FAIL same_cycle got stall=%b we=%b want stall=1 we=0", ld_stall, dm_we);
    end
    tick();
    st_valid = 1'b0;
    #1;
    n_cmp++; if (ld_stall !== 1'b1 || count !== 3'd1) begin
      n_err++; $display("FAIL same_cycle_held got stall=%b count=%0d want stall=1 count=1", ld_stall, count);
    end
    ld_valid = 1'b0;
    #1;
    n_cmp++; if (dm_we !== 1'b1 || dm_op !== 2'b10 || dm_addr !== 32'h30) begin
      n_err++; $display("FAIL same_cycle_drain got we=%b op=%b addr=%h want 1/10/00000030", dm_we, dm_op, dm_addr);
    end
    tick();
    idle();
  endtask

  task automatic test_wrap_order();
    logic [31:0] qa[$];
    logic [31:0] qd[$];
    int k = 0;
    int mc = 0;
    int wr = 0;
    int cyc = 0;
    logic exp_ready;
    logic exp_drain;
    while ((k < 10 || mc != 0) && cyc < 100) begin
      st_valid = (k < 10);
      st_addr  = 32'h1000 + 32'(4 * k);
      st_data  = 32'hD000 + 32'(k);
      st_op    = 2'(k % 3);
      st_pc    = 32'h8000 + 32'(4 * k);
      ld_valid = ((cyc % 3) != 0);
      ld_addr  = 32'h4000;
      ld_op    = 2'b00;
      #1;
      exp_ready = (mc != 4);
      exp_drain = (mc != 0) && (!ld_valid || mc == 4);
      n_cmp++; if (st_ready !== exp_ready || dm_we !== exp_drain || ld_stall !== (ld_valid && mc == 4)) begin
        n_err++; $display("FAIL wrap_ctl_c%0d got ready=%b we=%b stall=%b want %b/%b/%b",
                          cyc, st_ready, dm_we, ld_stall, exp_ready, exp_drain, ld_valid && mc == 4);
      end
      if (exp_drain) begin
        n_cmp++; if (dm_addr !== qa[0] || dm_wd !== qd[0]) begin
          n_err++; $display("FAIL wrap_order_c%0d got addr=%h wd=%h want addr=%h wd=%h",
                            cyc, dm_addr, dm_wd, qa[0], qd[0]);
        end
      end
      tick();
      if (exp_drain) begin
        void'(qa.pop_front());
        void'(qd.pop_front());
        mc--;
        wr++;
      end
      if (st_valid && exp_ready) begin
        qa.push_back(st_addr);
        qd.push_back(st_data);
        mc++;
        k++;
      end
      cyc++;
    end
    n_cmp++; if (wr !== 10) begin n_err++; $display("FAIL wrap_writes got %0d want 10", wr); end
    idle();
    #1;
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL wrap_count got %0d want 0", count); end
  endtask

  task automatic test_reset_mid();
    ld_valid = 1'b1; ld_addr = 32'h100;
    for (int i = 0; i < 3; i++) begin
      store(32'h500 + 32'(4 * i), 32'h77, 2'b00);
      tick();
    end
    st_valid = 1'b0;
    #1;
    n_cmp++; if (count !== 3'd3) begin n_err++; $display("FAIL mid_count3 got %0d want 3", count); end
    ld_valid = 1'b0;
    reset = 1'b0;
    #1;
    n_cmp++; if (dm_we !== 1'b0 || st_ready !== 1'b0) begin
      n_err++; $display("FAIL mid_in_reset got we=%b ready=%b want 0/0", dm_we, st_ready);
    end
    tick();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (dm_we !== 1'b0 || count !== 3'd0) begin
        n_err++; $display("FAIL mid_after_%0d got we=%b count=%0d want 0/0", i, dm_we, count);
      end
      tick();
    end
  endtask

  initial begin
    idle();
    reset = 1'b0;
    test_reset();
    test_single_store();
    test_fill();
    test_conflict();
    test_same_cycle();
    test_wrap_order();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
